// File: rtl/sargantana_itag_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sargantana_itag_ctrl
// Brief    : I-cache tag-store controller: lookup, way compare, victim choice
//            and tag refill write.
// Revision : 1.0
// ============================================================================
module sargantana_itag_ctrl #(
  parameter int ICACHE_N_WAY   = 4,
  parameter int TAG_DEPTH      = 64,
  parameter int TAG_ADDR_WIDHT = $clog2(TAG_DEPTH),
  parameter int TAG_WIDHT      = 20,
  parameter int WAY_IDX_W      = $clog2(ICACHE_N_WAY)
) (
  input  logic                                     clk_i,
  input  logic                                     rstn_i,
  input  logic                                     lookup_valid_i,
  output logic                                     lookup_ready_o,
  input  logic [TAG_ADDR_WIDHT-1:0]                lookup_idx_i,
  input  logic [TAG_WIDHT-1:0]                     lookup_tag_i,
  output logic                                     resp_valid_o,
  output logic                                     resp_hit_o,
  output logic [ICACHE_N_WAY-1:0]                  resp_way_o,
  output logic                                     miss_o,
  input  logic                                     refill_i,
  output logic                                     fill_done_o,
  input  logic                                     flush_i,
  output logic [ICACHE_N_WAY-1:0]                  mem_req_o,
  output logic                                     mem_we_o,
  output logic                                     mem_vbit_o,
  output logic                                     mem_flush_o,
  output logic [TAG_WIDHT-1:0]                     mem_data_o,
  output logic [TAG_ADDR_WIDHT-1:0]                mem_addr_o,
  input  logic [ICACHE_N_WAY-1:0][TAG_WIDHT-1:0]   mem_tag_way_i,
  input  logic [ICACHE_N_WAY-1:0]                  mem_vbit_i
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPARE = 2'd1,
    S_MISS    = 2'd2,
    S_FILL    = 2'd3
  } state_e;

  localparam logic [WAY_IDX_W-1:0] c_rr_one = WAY_IDX_W'(1);

  state_e                    r_state;
  logic [TAG_ADDR_WIDHT-1:0] r_idx;
  logic [TAG_WIDHT-1:0]      r_tag;
  logic [ICACHE_N_WAY-1:0]   r_victim;
  logic                      r_victim_rr;
  logic [WAY_IDX_W-1:0]      r_rr;

  logic [ICACHE_N_WAY-1:0]   w_hit_vec;
  logic [ICACHE_N_WAY-1:0]   w_hit_way;
  logic [ICACHE_N_WAY-1:0]   w_free_way;
  logic [ICACHE_N_WAY-1:0]   w_rr_way;
  logic [ICACHE_N_WAY-1:0]   w_victim;
  logic                      w_hit;
  logic                      w_all_valid;
  logic                      w_accept;
  logic                      w_fill;

  for (genvar w = 0; w < ICACHE_N_WAY; w++) begin : g_cmp
    assign w_hit_vec[w] = mem_vbit_i[w] & (mem_tag_way_i[w] == r_tag);
  end

  // Scan downwards so the lowest-index candidate is the one left standing.
  always_comb begin
    w_hit_way  = '0;
    w_free_way = '0;
    w_rr_way   = '0;
    for (int w = ICACHE_N_WAY - 1; w >= 0; w--) begin
      if (w_hit_vec[w]) begin
        w_hit_way    = '0;
        w_hit_way[w] = 1'b1;
      end
      if (!mem_vbit_i[w]) begin
        w_free_way    = '0;
        w_free_way[w] = 1'b1;
      end
    end
    w_rr_way[r_rr] = 1'b1;
  end

  assign w_hit       = |w_hit_vec;
  assign w_all_valid = &mem_vbit_i;
  assign w_victim    = w_all_valid ? w_rr_way : w_free_way;
  assign w_accept    = (r_state == S_IDLE) && lookup_valid_i && !flush_i;
  assign w_fill      = (r_state == S_FILL) && !flush_i;

  assign lookup_ready_o = (r_state == S_IDLE) && !flush_i;
  assign resp_valid_o   = (r_state == S_COMPARE) && !flush_i;
  assign resp_hit_o     = resp_valid_o && w_hit;
  assign resp_way_o     = !resp_valid_o ? '0 : (w_hit ? w_hit_way : w_victim);
  assign miss_o         = (r_state == S_MISS);
  assign fill_done_o    = w_fill;

  assign mem_flush_o = flush_i;
  assign mem_we_o    = w_fill;
  assign mem_vbit_o  = w_fill;
  assign mem_data_o  = w_fill ? r_tag : '0;
  assign mem_req_o   = w_accept ? '1 : (w_fill ? r_victim : '0);
  assign mem_addr_o  = w_accept ? lookup_idx_i : (w_fill ? r_idx : '0);

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_tag       <= '0;
      r_victim    <= '0;
      r_victim_rr <= 1'b0;
      r_rr        <= '0;
    end else if (flush_i) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (lookup_valid_i) begin
            r_idx   <= lookup_idx_i;
            r_tag   <= lookup_tag_i;
            r_state <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          if (w_hit) begin
            r_state <= S_IDLE;
          end else begin
            r_victim    <= w_victim;
            r_victim_rr <= w_all_valid;
            r_state     <= S_MISS;
          end
        end
        S_MISS: begin
          if (refill_i) r_state <= S_FILL;
        end
        S_FILL: begin
          // Pointer only advances when it actually picked the victim.
          if (r_victim_rr) r_rr <= r_rr + c_rr_one;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sargantana_itag_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sargantana_itag_ctrl
// Brief    : Scoreboard bench for sargantana_itag_ctrl with a tag-memory model.
// Revision : 1.0
// ============================================================================
module tb_sargantana_itag_ctrl;

  logic              clk_i = 1'b0;
  logic              rstn_i = 1'b0;
  logic              lookup_valid_i = 1'b0;
  logic              lookup_ready_o;
  logic [5:0]        lookup_idx_i = '0;
  logic [19:0]       lookup_tag_i = '0;
  logic              resp_valid_o;
  logic              resp_hit_o;
  logic [3:0]        resp_way_o;
  logic              miss_o;
  logic              refill_i = 1'b0;
  logic              fill_done_o;
  logic              flush_i = 1'b0;
  logic [3:0]        mem_req_o;
  logic              mem_we_o;
  logic              mem_vbit_o;
  logic              mem_flush_o;
  logic [19:0]       mem_data_o;
  logic [5:0]        mem_addr_o;
  logic [3:0][19:0]  mem_tag_way_i = '0;
  logic [3:0]        mem_vbit_i = '0;

  int n_asserts = 0;
  int n_fail    = 0;
  logic [4:0] exp_q[$];

  logic [19:0] tag_mem [4][64];
  logic        v_mem   [4][64];

  always #5 clk_i = ~clk_i;

  sargantana_itag_ctrl dut (
    .clk_i          (clk_i),
    .rstn_i         (rstn_i),
    .lookup_valid_i (lookup_valid_i),
    .lookup_ready_o (lookup_ready_o),
    .lookup_idx_i   (lookup_idx_i),
    .lookup_tag_i   (lookup_tag_i),
    .resp_valid_o   (resp_valid_o),
    .resp_hit_o     (resp_hit_o),
    .resp_way_o     (resp_way_o),
    .miss_o         (miss_o),
    .refill_i       (refill_i),
    .fill_done_o    (fill_done_o),
    .flush_i        (flush_i),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_vbit_o     (mem_vbit_o),
    .mem_flush_o    (mem_flush_o),
    .mem_data_o     (mem_data_o),
    .mem_addr_o     (mem_addr_o),
    .mem_tag_way_i  (mem_tag_way_i),
    .mem_vbit_i     (mem_vbit_i)
  );

  // Tag memory with registered read data, one entry per way.
  always @(posedge clk_i) begin
    if (mem_flush_o) begin
      for (int w = 0; w < 4; w++)
        for (int i = 0; i < 64; i++) v_mem[w][i] <= 1'b0;
    end else if (mem_we_o) begin
      for (int w = 0; w < 4; w++)
        if (mem_req_o[w]) begin
          tag_mem[w][mem_addr_o] <= mem_data_o;
          v_mem[w][mem_addr_o]   <= mem_vbit_o;
        end
    end
    if (|mem_req_o && !mem_we_o) begin
      for (int w = 0; w < 4; w++) begin
        mem_tag_way_i[w] <= tag_mem[w][mem_addr_o];
        mem_vbit_i[w]    <= v_mem[w][mem_addr_o];
      end
    end
  end

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk_i) begin
    if (resp_valid_o) begin
      if (exp_q.size() == 0) begin
        chk_eq("resp_unexpected", 64'd1, 64'd0);
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        chk_eq("resp_hit", resp_hit_o, e[4]);
        chk_eq("resp_way", resp_way_o, e[3:0]);
      end
    end
  end

  task automatic lookup(input logic [5:0] idx, input logic [19:0] tag,
                        input logic hit, input logic [3:0] way);
    @(negedge clk_i);
    lookup_valid_i = 1'b1;
    lookup_idx_i   = idx;
    lookup_tag_i   = tag;
    #1;
    chk_eq("lookup_ready", lookup_ready_o, 1'b1);
    chk_eq("rd_req", mem_req_o, 4'b1111);
    chk_eq("rd_addr", mem_addr_o, idx);
    exp_q.push_back({hit, way});
    @(posedge clk_i); #1;
    lookup_valid_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  task automatic refill(input logic [3:0] way, input logic [5:0] idx, input logic [19:0] tag);
    @(negedge clk_i);
    chk_eq("miss_level", miss_o, 1'b1);
    chk_eq("miss_mem_idle", mem_req_o, 4'b0000);
    refill_i = 1'b1;
    @(posedge clk_i); #1;
    refill_i = 1'b0;
    @(negedge clk_i);
    chk_eq("fill_we", mem_we_o, 1'b1);
    chk_eq("fill_req", mem_req_o, way);
    chk_eq("fill_addr", mem_addr_o, idx);
    chk_eq("fill_data", mem_data_o, tag);
    chk_eq("fill_vbit", mem_vbit_o, 1'b1);
    chk_eq("fill_done", fill_done_o, 1'b1);
    @(posedge clk_i); #1;
    chk_eq("fill_back_idle", lookup_ready_o, 1'b1);
  endtask

  task automatic miss_fill(input logic [5:0] idx, input logic [19:0] tag, input logic [3:0] way);
    lookup(idx, tag, 1'b0, way);
    refill(way, idx, tag);
  endtask

  task automatic chk_quiet(input string tag);
    chk_eq({tag, "_we"}, mem_we_o, 1'b0);
    chk_eq({tag, "_req"}, mem_req_o, 4'b0000);
    chk_eq({tag, "_fill_done"}, fill_done_o, 1'b0);
    chk_eq({tag, "_miss"}, miss_o, 1'b0);
    chk_eq({tag, "_resp_valid"}, resp_valid_o, 1'b0);
    chk_eq({tag, "_ready"}, lookup_ready_o, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset with flush to clear the memory model's valid bits.
    rstn_i  = 1'b0;
    flush_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 flush_i = 1'b0;
    @(negedge clk_i);
    chk_quiet("reset");
    chk_eq("reset_data", mem_data_o, 20'h0);
    chk_eq("reset_flush", mem_flush_o, 1'b0);
    @(posedge clk_i); #1 rstn_i = 1'b1;

    // Cold miss, fill, re-lookup hit.
    lookup(6'd5, 20'hABCDE, 1'b0, 4'b0001);
    refill(4'b0001, 6'd5, 20'hABCDE);
    lookup(6'd5, 20'hABCDE, 1'b1, 4'b0001);

    // Fill all ways of set 3 invalid-first, then round-robin victims.
    for (int i = 0; i < 4; i++)
      miss_fill(6'd3, 20'h30000 + 20'(i), 4'b0001 << i);
    miss_fill(6'd3, 20'h30004, 4'b0001);
    miss_fill(6'd3, 20'h30005, 4'b0010);
    lookup(6'd3, 20'h30002, 1'b1, 4'b0100);
    lookup(6'd3, 20'h30005, 1'b1, 4'b0010);

    // Round-robin through rr=3 and wrap back to 0.
    miss_fill(6'd3, 20'h30006, 4'b0100);
    miss_fill(6'd3, 20'h30007, 4'b1000);
    lookup(6'd3, 20'h30008, 1'b0, 4'b0001);

    // Flush while in MISS; the late refill must be ignored.
    @(negedge clk_i);
    flush_i = 1'b1;
    #1;
    chk_eq("flush_miss_pass", mem_flush_o, 1'b1);
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    @(negedge clk_i);
    chk_eq("flush_miss_idle", miss_o, 1'b0);
    chk_eq("flush_miss_ready", lookup_ready_o, 1'b1);
    refill_i = 1'b1;
    @(posedge clk_i); #1;
    refill_i = 1'b0;
    @(negedge clk_i);
    chk_quiet("stale_refill");
    @(posedge clk_i); #1;

    // Flush in COMPARE together with a new lookup request.
    miss_fill(6'd7, 20'h77777, 4'b0001);
    lookup(6'd7, 20'h77777, 1'b1, 4'b0001);
    @(negedge clk_i);
    lookup_valid_i = 1'b1;
    lookup_idx_i   = 6'd7;
    lookup_tag_i   = 20'h77777;
    @(posedge clk_i); #1;
    flush_i = 1'b1;
    #1;
    chk_eq("flush_cmp_resp", resp_valid_o, 1'b0);
    chk_eq("flush_cmp_ready", lookup_ready_o, 1'b0);
    chk_eq("flush_cmp_req", mem_req_o, 4'b0000);
    chk_eq("flush_cmp_pass", mem_flush_o, 1'b1);
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    lookup_valid_i = 1'b0;
    miss_fill(6'd7, 20'h77777, 4'b0001);

    // Reset while in FILL, with rr advanced to 1 beforehand.
    for (int i = 0; i < 4; i++)
      miss_fill(6'd9, 20'h90000 + 20'(i), 4'b0001 << i);
    miss_fill(6'd9, 20'h90004, 4'b0001);
    lookup(6'd9, 20'h90005, 1'b0, 4'b0010);
    @(negedge clk_i);
    refill_i = 1'b1;
    @(posedge clk_i); #1;
    refill_i = 1'b0;
    rstn_i   = 1'b0;
    @(posedge clk_i); #1;
    chk_quiet("rst_fill");
    @(posedge clk_i); #1;
    rstn_i = 1'b1;
    @(negedge clk_i);
    chk_quiet("post_rst");
    @(posedge clk_i); #1;
    miss_fill(6'd9, 20'h90006, 4'b0001);
    lookup(6'd9, 20'h90006, 1'b1, 4'b0001);

    repeat (2) @(posedge clk_i);
    chk_eq("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sargantana_itag_ctrl.md
# sargantana_itag_ctrl

Initiator-side controller for the instruction-cache tag store. It accepts fetch lookups (set index plus tag), issues the read to the per-way tag/valid memory, and compares all ways. It reports hit or miss with the matching way, and on a miss selects a victim way and writes the new tag with its valid bit once the refill arrives. It sits between the fetch/refill logic and the tag memory, and is the only agent driving that memory's request port.

## Interface
- ICACHE_N_WAY, 4, number of ways; power of two, ≥2
- TAG_DEPTH, 64, sets per way
- TAG_ADDR_WIDHT, $clog2(TAG_DEPTH), set index width
- TAG_WIDHT, 20, tag width
- WAY_IDX_W, $clog2(ICACHE_N_WAY), width of the round-robin counter
- clk_i  in  1  clock; all state updates on the rising edge
- rstn_i  in  1  reset, synchronous, active-low
- lookup_valid_i  in  1  lookup request
- lookup_ready_o  out  1  lookup accepted when valid & ready
- lookup_idx_i  in  TAG_ADDR_WIDHT  set index
- lookup_tag_i  in  TAG_WIDHT  tag to compare
- resp_valid_o  out  1  one-cycle response pulse; no backpressure
- resp_hit_o  out  1  hit flag, qualified by resp_valid_o
- resp_way_o  out  ICACHE_N_WAY  one-hot hit way, or one-hot victim way on a miss
- miss_o  out  1  level; high while waiting for the refill
- refill_i  in  1  pulse; the refill data for the pending miss is available
- fill_done_o  out  1  pulse; the tag write has been issued
- flush_i  in  1  invalidate all ways
- mem_req_o  out  ICACHE_N_WAY  per-way request to the tag memory
- mem_we_o  out  1  write enable
- mem_vbit_o  out  1  valid bit to write
- mem_flush_o  out  1  clears all valid bits
- mem_data_o  out  TAG_WIDHT  tag to write
- mem_addr_o  out  TAG_ADDR_WIDHT  set index
- mem_tag_way_i  in  ICACHE_N_WAY×TAG_WIDHT  registered tag read data, one entry per way
- mem_vbit_i  in  ICACHE_N_WAY  registered valid bits

## Operation
- **States:** IDLE, COMPARE, MISS, FILL. Registers: idx_q, tag_q, victim_q (one-hot), rr_q (WAY_IDX_W bits).
- **IDLE**
  - lookup_ready_o = !flush_i.
  - On accept: mem_req_o = all ones, mem_we_o = 0, mem_addr_o = lookup_idx_i. Capture idx_q and tag_q, then go to COMPARE.
- **COMPARE**
  - hit_vec[w] = mem_vbit_i[w] & (mem_tag_way_i[w] == tag_q).
  - resp_valid_o = 1.
  - **Hit:** resp_hit_o = 1. resp_way_o = lowest set bit of hit_vec; multi-hit resolves to the lowest index. Return to IDLE.
  - **Miss:** resp_hit_o = 0. Victim = lowest-index way with mem_vbit_i = 0; if all ways are valid, victim = one-hot(rr_q). resp_way_o = victim. Capture victim_q and go to MISS.
- **MISS**
  - miss_o = 1; memory idle.
  - refill_i moves the FSM to FILL.
- **FILL**
  - mem_req_o = victim_q, mem_we_o = 1, mem_vbit_o = 1, mem_addr_o = idx_q, mem_data_o = tag_q.
  - fill_done_o = 1.
  - rr_q increments modulo ICACHE_N_WAY only when the victim came from rr_q; wrap from N−1 to 0.
  - Return to IDLE. The requester re-issues the lookup.
- **Flush** (any state)
  - mem_flush_o = flush_i, combinational pass-through.
  - Next state is IDLE; a pending miss is abandoned with no fill_done_o.
  - A flush in COMPARE suppresses resp_valid_o in that cycle.
  - A flush has priority over a simultaneous lookup (not accepted) and over refill_i.
- refill_i outside MISS is ignored.
- mem_data_o and mem_vbit_o are 0 when mem_we_o = 0.

## Timing
- **Reset values:** state = IDLE, rr_q = 0, all registers 0. All outputs are 0 except lookup_ready_o, which follows IDLE (1 when flush_i = 0).
- **Lookup latency:** accept in cycle T; response in cycle T+1.
- **Next lookup:** accepted at T+2 after a hit.
- **Miss sequence:** refill_i at cycle R gives the FILL write and fill_done_o at R+1; IDLE at R+2.
- **Outputs:** memory-side outputs are combinational from state, registers and IDLE inputs. Response outputs are combinational in COMPARE.
- **Reset mid-operation:** on the reset edge the FSM returns to IDLE; no write is issued afterward.

## Test plan
- **Cold miss then fill.**
  - After reset, lookup idx=5 tag=0xABCDE gives resp_valid at T+1 with hit=0, way=0001; miss_o=1.
  - refill_i gives a write with mem_req_o=0001, addr=5, data=0xABCDE, vbit=1, plus fill_done_o.
  - Re-lookup gives hit=1, way=0001.
- **Fill all 4 ways of idx 3.** Victims are 0001, 0010, 0100, 1000 (invalid-first). A fifth distinct tag gives victim 0001 (rr_q=0); a sixth gives 0010.
- **Round-robin wrap.** With rr_q=3, a full-set miss gives victim 1000 and rr_q wraps to 0.
- **Flush in MISS.** flush_i gives mem_flush_o=1 in the same cycle and IDLE next. A later refill_i is ignored, with no write and no fill_done_o.
- **Flush in COMPARE with a simultaneous lookup.** resp_valid_o=0 and lookup_ready_o=0 that cycle; the next lookup of the same tag misses.
- **Reset asserted in FILL.** No write occurs after the reset edge; all outputs take their reset values and rr_q=0.
